// File: rtl/regress_accum.sv
// regress_accum: accumulates the six moment sums (n, Sx, Sy, Sxy, Sx2, Sy2)
// of an (x, y) sample stream over a window. It then hands the frozen sums to
// the least-squares solver and waits for the solver to finish, or gives up
// after a bounded wait.
module regress_accum #(
    parameter int DATA_W        = 8,   // sample width, at most 16 so products fit 32 bits
    parameter int WIN           = 64,  // samples per window (>= 2)
    parameter int SOLVE_TIMEOUT = 63   // WAIT cycles before the solve is abandoned (>= 1)
) (
    input  logic              clk,
    input  logic              reset,        // synchronous, active low
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_x,
    input  logic [DATA_W-1:0] s_y,
    input  logic              s_last,
    output logic [15:0]       n,
    output logic [15:0]       sig_x,
    output logic [15:0]       sig_y,
    output logic [31:0]       sig_xy,
    output logic [31:0]       sig_x2,
    output logic [31:0]       sig_y2,
    output logic              en,
    output logic              start,
    input  logic              solve_done,
    output logic              overflow,
    output logic              short_window,
    output logic              timeout
);

    localparam int PW = 2 * DATA_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_LAUNCH,
        S_WAIT,
        S_CLEAR
    } state_t;

    state_t state_q;

    // Narrow sums: index 0 = Sx, 1 = Sy. Wide sums: 0 = Sxy, 1 = Sx2, 2 = Sy2.
    logic [1:0][15:0]       narrow_q;
    logic [2:0][31:0]       wide_q;
    logic [15:0]            n_q;
    logic [15:0]            wait_cnt_q;
    logic                   s_ready_q;
    logic                   en_q;
    logic                   start_q;
    logic                   overflow_q;
    logic                   short_q;
    logic                   timeout_q;

    logic [1:0][DATA_W-1:0] samp;
    logic [2:0][PW-1:0]     prod;
    logic [1:0][16:0]       narrow_sum;
    logic [2:0][32:0]       wide_sum;
    logic [1:0][15:0]       narrow_d;
    logic [2:0][31:0]       wide_d;
    logic [1:0]             narrow_ovf;
    logic [2:0]             wide_ovf;
    logic                   sat_hit;
    logic [15:0]            n_d;
    logic                   close_win;

    assign samp[0] = s_x;
    assign samp[1] = s_y;
    assign prod[0] = PW'(s_x) * PW'(s_y);
    assign prod[1] = PW'(s_x) * PW'(s_x);
    assign prod[2] = PW'(s_y) * PW'(s_y);

    // Saturating adders: one spare carry bit detects the wrap and clamps to all-ones.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_narrow
            assign narrow_sum[gi] = {1'b0, narrow_q[gi]} + 17'(samp[gi]);
            assign narrow_ovf[gi] = narrow_sum[gi][16];
            assign narrow_d[gi]   = narrow_ovf[gi] ? 16'hFFFF : narrow_sum[gi][15:0];
        end
        for (genvar gi = 0; gi < 3; gi++) begin : g_wide
            assign wide_sum[gi] = {1'b0, wide_q[gi]} + 33'(prod[gi]);
            assign wide_ovf[gi] = wide_sum[gi][32];
            assign wide_d[gi]   = wide_ovf[gi] ? 32'hFFFF_FFFF : wide_sum[gi][31:0];
        end
    endgenerate

    assign sat_hit   = (|narrow_ovf) | (|wide_ovf);
    assign n_d       = n_q + 16'd1;
    assign close_win = (n_d == 16'(WIN)) || s_last;

    // Window control FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            narrow_q   <= '0;
            wide_q     <= '0;
            n_q        <= '0;
            wait_cnt_q <= '0;
            s_ready_q  <= 1'b0;
            en_q       <= 1'b0;
            start_q    <= 1'b0;
            overflow_q <= 1'b0;
            short_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            start_q   <= 1'b0;
            short_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q   <= S_ACCUM;
                    s_ready_q <= 1'b1;
                end
                S_ACCUM: begin
                    if (!s_ready_q) begin
                        // First ACCUM cycle after CLEAR: reopen the input.
                        s_ready_q <= 1'b1;
                    end else if (s_valid) begin
                        if (close_win && (n_d < 16'd2)) begin
                            // A window of one sample cannot be solved; discard it.
                            narrow_q   <= '0;
                            wide_q     <= '0;
                            n_q        <= '0;
                            overflow_q <= 1'b0;
                            short_q    <= 1'b1;
                        end else begin
                            narrow_q   <= narrow_d;
                            wide_q     <= wide_d;
                            n_q        <= n_d;
                            overflow_q <= overflow_q | sat_hit;
                            if (close_win) begin
                                state_q   <= S_LAUNCH;
                                s_ready_q <= 1'b0;
                            end
                        end
                    end
                end
                S_LAUNCH: begin
                    // solve_done is deliberately not looked at here.
                    en_q       <= 1'b1;
                    start_q    <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (solve_done) begin
                        state_q <= S_CLEAR;
                    end else if (wait_cnt_q == 16'(SOLVE_TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_CLEAR;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end
                S_CLEAR: begin
                    en_q       <= 1'b0;
                    narrow_q   <= '0;
                    wide_q     <= '0;
                    n_q        <= '0;
                    overflow_q <= 1'b0;
                    state_q    <= S_ACCUM;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_ready      = s_ready_q;
    assign n            = n_q;
    assign sig_x        = narrow_q[0];
    assign sig_y        = narrow_q[1];
    assign sig_xy       = wide_q[0];
    assign sig_x2       = wide_q[1];
    assign sig_y2       = wide_q[2];
    assign en           = en_q;
    assign start        = start_q;
    assign overflow     = overflow_q;
    assign short_window = short_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_regress_accum.sv
// Bench for regress_accum: two instances (WIN=64 and WIN=300) sharing clock and
// reset, driven by directed and random windows and checked against a
// sum-of-samples reference model.
module tb_regress_accum;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_valid [2];
    logic        s_last [2];
    logic        solve_done [2];
    logic [7:0]  s_x [2];
    logic [7:0]  s_y [2];
    logic        s_ready [2];
    logic        en [2];
    logic        start [2];
    logic        overflow [2];
    logic        short_window [2];
    logic        timeout [2];
    logic [15:0] n_o [2];
    logic [15:0] sx_o [2];
    logic [15:0] sy_o [2];
    logic [31:0] sxy_o [2];
    logic [31:0] sx2_o [2];
    logic [31:0] sy2_o [2];

    int n_cmp = 0;
    int n_err = 0;
    int qx [$];
    int qy [$];

    always #5 clk = ~clk;

    regress_accum #(.DATA_W(8), .WIN(64), .SOLVE_TIMEOUT(63)) dut0 (
        .clk(clk), .reset(reset), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_x(s_x[0]), .s_y(s_y[0]), .s_last(s_last[0]), .n(n_o[0]),
        .sig_x(sx_o[0]), .sig_y(sy_o[0]), .sig_xy(sxy_o[0]), .sig_x2(sx2_o[0]),
        .sig_y2(sy2_o[0]), .en(en[0]), .start(start[0]), .solve_done(solve_done[0]),
        .overflow(overflow[0]), .short_window(short_window[0]), .timeout(timeout[0])
    );

    regress_accum #(.DATA_W(8), .WIN(300), .SOLVE_TIMEOUT(63)) dut1 (
        .clk(clk), .reset(reset), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_x(s_x[1]), .s_y(s_y[1]), .s_last(s_last[1]), .n(n_o[1]),
        .sig_x(sx_o[1]), .sig_y(sy_o[1]), .sig_xy(sxy_o[1]), .sig_x2(sx2_o[1]),
        .sig_y2(sy2_o[1]), .en(en[1]), .start(start[1]), .solve_done(solve_done[1]),
        .overflow(overflow[1]), .short_window(short_window[1]), .timeout(timeout[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: true total of the window's samples, clamped to the port range.
    function automatic longint model_sum(input int kind);
        longint t = 0;
        for (int i = 0; i < qx.size(); i++) begin
            case (kind)
                0: t += qx[i];
                1: t += qy[i];
                2: t += qx[i] * qy[i];
                3: t += qx[i] * qx[i];
                default: t += qy[i] * qy[i];
            endcase
        end
        return t;
    endfunction

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic model_ovf();
        return (model_sum(0) > 64'hFFFF) || (model_sum(1) > 64'hFFFF) ||
               (model_sum(2) > 64'hFFFF_FFFF) || (model_sum(3) > 64'hFFFF_FFFF) ||
               (model_sum(4) > 64'hFFFF_FFFF);
    endfunction

    task automatic check_sums(input int sel);
        chk("n", n_o[sel], 64'(qx.size()));
        chk("sig_x", sx_o[sel], sat(model_sum(0), 64'hFFFF));
        chk("sig_y", sy_o[sel], sat(model_sum(1), 64'hFFFF));
        chk("sig_xy", sxy_o[sel], sat(model_sum(2), 64'hFFFF_FFFF));
        chk("sig_x2", sx2_o[sel], sat(model_sum(3), 64'hFFFF_FFFF));
        chk("sig_y2", sy2_o[sel], sat(model_sum(4), 64'hFFFF_FFFF));
        chk("overflow", overflow[sel], 64'(model_ovf()));
    endtask

    // Present one sample and hold it until accepted; returns at accept edge + 1.
    task automatic push(input int sel, input int x, input int y, input logic last);
        bit done = 0;
        s_valid[sel] = 1'b1;
        s_x[sel]     = 8'(x);
        s_y[sel]     = 8'(y);
        s_last[sel]  = last;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (s_ready[sel]) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        s_valid[sel] = 1'b0;
        s_last[sel]  = 1'b0;
        if (done) begin
            qx.push_back(x);
            qy.push_back(y);
            $display("push dut%0d x=%0d y=%0d last=%0d n=%0d", sel, x, y, last, n_o[sel]);
        end else begin
            n_cmp++;
            n_err++;
            $error("FAIL push_accept observed=stalled expected=accepted");
        end
    endtask

    // Called right after the closing acceptance edge; runs LAUNCH/WAIT/CLEAR.
    task automatic check_launch(input int sel, input int done_delay);
        chk("close_s_ready", s_ready[sel], 0);
        chk("close_en", en[sel], 0);
        chk("close_start", start[sel], 0);
        @(posedge clk); #1;
        chk("launch_en", en[sel], 1);
        chk("launch_start", start[sel], 1);
        check_sums(sel);
        @(posedge clk); #1;
        chk("wait_start", start[sel], 0);
        chk("wait_en", en[sel], 1);
        repeat (done_delay) @(posedge clk);
        #1;
        chk("wait_n_held", n_o[sel], 64'(qx.size()));
        chk("wait_timeout", timeout[sel], 0);
        solve_done[sel] = 1'b1;
        @(posedge clk); #1;
        solve_done[sel] = 1'b0;
        chk("done_en_held", en[sel], 1);
        chk("done_s_ready", s_ready[sel], 0);
        @(posedge clk); #1;
        chk("clear_en", en[sel], 0);
        chk("clear_n", n_o[sel], 0);
        chk("clear_sig_xy", sxy_o[sel], 0);
        chk("clear_overflow", overflow[sel], 0);
        chk("clear_s_ready", s_ready[sel], 0);
        @(posedge clk); #1;
        chk("reopen_s_ready", s_ready[sel], 1);
        $display("window dut%0d solved n=%0d", sel, qx.size());
        qx.delete();
        qy.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            s_valid[s] = 0; s_last[s] = 0; solve_done[s] = 0; s_x[s] = 0; s_y[s] = 0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready[0], 0);
        chk("rst_en", en[0], 0);
        chk("rst_n", n_o[0], 0);
        chk("rst_overflow", overflow[1], 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rel_s_ready", s_ready[0], 1);
        chk("rel_en", en[0], 0);

        // Directed 4-sample window closed by s_last
        push(0, 1, 2, 0); push(0, 2, 4, 0); push(0, 3, 6, 0); push(0, 4, 8, 1);
        chk("dir_sig_xy", sxy_o[0], 60);
        chk("dir_sig_y2", sy2_o[0], 120);
        check_launch(0, 3);

        // Random windows
        for (int w = 0; w < 4; w++) begin
            int len = $urandom_range(2, 12);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                push(0, $urandom_range(0, 255), $urandom_range(0, 255), i == len - 1);
            end
            check_launch(0, $urandom_range(0, 20));
        end

        // Full window of 64 at maximum value; a 65th sample waits for CLEAR
        for (int i = 0; i < 64; i++) push(0, 255, 255, 0);
        chk("full_sig_x", sx_o[0], 16320);
        chk("full_sig_x2", sx2_o[0], 4161600);
        s_valid[0] = 1'b1; s_x[0] = 8'd7; s_y[0] = 8'd9;
        check_launch(0, 5);
        @(posedge clk); #1;
        s_valid[0] = 1'b0;
        qx.push_back(7); qy.push_back(9);
        chk("held_n", n_o[0], 1);
        chk("held_sig_x", sx_o[0], 7);
        push(0, 1, 1, 1);
        check_launch(0, 2);

        // WIN=300 instance: saturation and overflow
        for (int i = 0; i < 300; i++) push(1, 255, 255, 0);
        chk("sat_overflow_early", overflow[1], 1);
        check_launch(1, 4);

        // Lone s_last sample: short window
        push(0, 9, 9, 1);
        chk("short_pulse", short_window[0], 1);
        chk("short_n", n_o[0], 0);
        chk("short_s_ready", s_ready[0], 1);
        chk("short_en", en[0], 0);
        @(posedge clk); #1;
        chk("short_end", short_window[0], 0);
        chk("short_no_start", start[0], 0);
        qx.delete(); qy.delete();

        // Timeout; solve_done in the LAUNCH cycle alone is ignored
        push(0, 3, 4, 0);
        push(0, 5, 6, 1);
        solve_done[0] = 1'b1;
        @(posedge clk); #1;
        solve_done[0] = 1'b0;
        chk("to_start", start[0], 1);
        for (int i = 0; i < 62; i++) begin
            @(posedge clk); #1;
            chk("to_early", timeout[0], 0);
            chk("to_en", en[0], 1);
        end
        @(posedge clk); #1;
        chk("to_pulse", timeout[0], 1);
        @(posedge clk); #1;
        chk("to_end", timeout[0], 0);
        chk("to_clear_en", en[0], 0);
        @(posedge clk); #1;
        chk("to_s_ready", s_ready[0], 1);
        qx.delete(); qy.delete();

        // Reset during WAIT
        push(0, 10, 20, 0);
        push(0, 30, 40, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rw_en", en[0], 0);
            chk("rw_start", start[0], 0);
            chk("rw_timeout", timeout[0], 0);
            chk("rw_n", n_o[0], 0);
            chk("rw_sig_x2", sx2_o[0], 0);
            chk("rw_s_ready", s_ready[0], 0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rw_rel_s_ready", s_ready[0], 1);
        qx.delete(); qy.delete();

        // Reset during ACCUM, then a clean window
        push(0, 100, 50, 0); push(0, 60, 70, 0); push(0, 80, 90, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("ra_n", n_o[0], 0);
        chk("ra_sig_x", sx_o[0], 0);
        chk("ra_s_ready", s_ready[0], 0);
        reset = 1'b1;
        @(posedge clk); #1;
        qx.delete(); qy.delete();
        push(0, $urandom_range(0, 255), $urandom_range(0, 255), 0);
        push(0, $urandom_range(0, 255), $urandom_range(0, 255), 0);
        push(0, $urandom_range(0, 255), $urandom_range(0, 255), 1);
        check_launch(0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
